vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator. Successor to the fixed 640x480 counter block.
//  Porch and sync widths, and sync polarity, are parameters; pixel-rate clock enable.
//  Syncs/blanking delayed PIPE_DLY pixel ticks to align with the downstream pixel pipeline.
//  Outputs x/y (undelayed, for addressing), sync/video (delayed), sof/eol strobes, frame counter.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  SYNC_POL  0    0 = syncs active-low, 1 = active-high
//  PIPE_DLY  2    pixel-tick delay on hsync/vsync/video_on/sof (0..15)
//  CNT_W     11   x/y counter width; H_TOTAL and V_TOTAL must be <= 2**CNT_W
//  FRAME_W   8    frame counter width
// PORTS
//  clk       in   1        system clock
//  rst       in   1        synchronous reset, active-high
//  pix_ce    in   1        pixel tick; all counters/delay stages advance only when 1
//  x         out  CNT_W    horizontal count 0..H_TOTAL-1 (undelayed)
//  y         out  CNT_W    vertical count 0..V_TOTAL-1 (undelayed)
//  hsync     out  1        horizontal sync, polarity SYNC_POL, delayed PIPE_DLY
//  vsync     out  1        vertical sync, polarity SYNC_POL, delayed PIPE_DLY
//  video_on  out  1        active-area flag, delayed PIPE_DLY
//  sof       out  1        start-of-frame strobe, delayed PIPE_DLY
//  eol       out  1        end-of-line strobe (undelayed)
//  frame_cnt out  FRAME_W  completed-frame count
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL = sum of V_* (525 default).
//  - Reset: x=y=0, frame_cnt=0, video_on=0, sof=0, eol=0, hsync=vsync=~SYNC_POL.
//    All delay stages load these inactive values. No output glitch after reset release.
//  - pix_ce=1: x increments. At x=H_TOTAL-1, x wraps to 0 and y increments.
//    At y=V_TOTAL-1 and x=H_TOTAL-1, y wraps to 0 and frame_cnt increments (mod 2**FRAME_W).
//  - pix_ce=0: x, y, frame_cnt and all delay stages hold. Strobes are forced to 0.
//  - Raw decode from current (x,y):
//    h_act = x<H_ACTIVE
//    h_sy = H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC
//    v_act and v_sy: same form on y
//    video_on = h_act&v_act; hsync = h_sy ^ ~SYNC_POL; vsync = v_sy ^ ~SYNC_POL
//  - Raw sof = (x==0 && y==0 && pix_ce); eol = (x==H_TOTAL-1 && pix_ce). Each is 1 clk wide.
//  - Delay line: raw {hsync,vsync,video_on,sof_flag} shift one stage per pix_ce.
//    Output = stage PIPE_DLY. PIPE_DLY=0 makes outputs combinational from x/y.
//    Delayed sof is qualified by pix_ce on the output cycle.
//  - Latency: hsync/vsync/video_on/sof lag x/y by exactly PIPE_DLY pixel ticks.
//  - Widths: comparisons are unsigned CNT_W-bit; sums are computed as localparams (integer).
//  - Reset mid-frame: on the next clk, counters return to 0 and the delay line flushes to inactive.
//    The first sof appears PIPE_DLY ticks later.
//  - vsync transitions align with x=0 (line-aligned). Frame wrap and line wrap occur on the same tick.
// STRUCTURE
//  - Package vga_timing_pkg: timing localparam sets VGA_640x480_60 and SVGA_800x600_60.
//    Also holds a polarity enum and an H_TOTAL/V_TOTAL helper function.
//  - Sub-module vga_delay_line (WIDTH, DEPTH, RST_VAL).
//    Pix_ce-enabled shift register; DEPTH=0 is a passthrough.
//  - Top: two counters, decode, one vga_delay_line instance.
// TESTING
//  - Defaults, pix_ce=1 always, PIPE_DLY=0:
//    hsync low for x=656..751; vsync low for y=490..491; video_on for x<640,y<480; 800x525 period.
//  - pix_ce every 4th clk: x advances 1 per 4 clks; sof/eol exactly 1 clk wide; frame = 1,680,000 clks.
//  - PIPE_DLY=3: hsync falling edge is seen 3 pixel ticks after x becomes 656; sof 3 ticks after (0,0).
//  - SYNC_POL=1, H_SYNC=128, V_SYNC=4 (800x600 set): hsync high for x=840..967; V_TOTAL=628.
//  - Assert rst at x=300,y=200: next clk x=y=0, syncs inactive, video_on=0; sof after PIPE_DLY ticks.
//  - FRAME_W=2: run 5 frames -> frame_cnt sequence 0,1,2,3,0,1; increments on the tick y,x wrap to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types: mode tables, sync polarity, control-bundle layout.
package vga_timing_pkg;

    typedef enum logic {
        POL_NEG = 1'b0,
        POL_POS = 1'b1
    } sync_pol_e;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
        sync_pol_e pol;
    } vga_mode_t;

    // Bundle carried through the pixel-aligned delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
        logic sof;
    } vga_ctl_t;

    localparam vga_mode_t VGA_640x480_60 = '{
        h:   '{active: 640, fp: 16, sync: 96,  bp: 48},
        v:   '{active: 480, fp: 10, sync: 2,   bp: 33},
        pol: POL_NEG
    };

    localparam vga_mode_t SVGA_800x600_60 = '{
        h:   '{active: 800, fp: 40, sync: 128, bp: 88},
        v:   '{active: 600, fp: 1,  sync: 4,   bp: 23},
        pol: POL_POS
    };

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the generator (master) and the pixel pipeline (slave).
interface vga_timing_if #(
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned FRAME_W = 8
);
    logic               pix_ce;
    logic [CNT_W-1:0]   x;
    logic [CNT_W-1:0]   y;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               sof;
    logic               eol;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  pix_ce,
        output x, y, hsync, vsync, video_on, sof, eol, frame_cnt
    );

    modport slave (
        output pix_ce,
        input  x, y, hsync, vsync, video_on, sof, eol, frame_cnt
    );
endinterface

// File: rtl/vga_delay_line.sv
// Pixel-tick-enabled shift register; DEPTH=0 is a combinational passthrough.
module vga_delay_line #(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     DEPTH   = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Forced inactive during reset so the zero-latency path matches the registered one
            logic unused_c;
            assign unused_c = clk ^ ce;
            assign q        = rst ? RST_VAL : d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else if (ce) begin
                    stage_q[0] <= d;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: x/y counters, sync/blank decode,
// and a pixel-aligned delay line on the control bundle.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY = 2,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned FRAME_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vif
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    // One extra bit keeps the decode bounds exact even when a total equals 2**CNT_W
    localparam int unsigned XW      = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [XW-1:0]    H_ACT_END = XW'(H_ACTIVE);
    localparam logic [XW-1:0]    H_SY_BEG  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0]    H_SY_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0]    V_ACT_END = XW'(V_ACTIVE);
    localparam logic [XW-1:0]    V_SY_BEG  = XW'(V_ACTIVE + V_FP);
    localparam logic [XW-1:0]    V_SY_END  = XW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic     SYNC_IDLE = ~SYNC_POL;
    localparam vga_ctl_t CTL_IDLE  = '{hsync: SYNC_IDLE, vsync: SYNC_IDLE,
                                       video_on: 1'b0, sof: 1'b0};

    logic [CNT_W-1:0]   x_q;
    logic [CNT_W-1:0]   y_q;
    logic [FRAME_W-1:0] frame_q;
    logic [XW-1:0]      x_ext_c;
    logic [XW-1:0]      y_ext_c;
    logic               line_end_c;
    logic               frame_end_c;
    vga_ctl_t           raw_c;
    vga_ctl_t           dly_c;

    assign line_end_c  = (x_q == H_LAST);
    assign frame_end_c = line_end_c && (y_q == V_LAST);

    // Raster counters; line and frame wrap land on the same pixel tick
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else if (vif.pix_ce) begin
            if (line_end_c) begin
                x_q <= '0;
                if (frame_end_c) begin
                    y_q     <= '0;
                    frame_q <= frame_q + FRAME_W'(1);
                end else begin
                    y_q <= y_q + CNT_W'(1);
                end
            end else begin
                x_q <= x_q + CNT_W'(1);
            end
        end
    end

    // Raw decode from the current raster position
    always_comb begin
        raw_c    = CTL_IDLE;
        x_ext_c  = {1'b0, x_q};
        y_ext_c  = {1'b0, y_q};
        raw_c.video_on = (x_ext_c < H_ACT_END) && (y_ext_c < V_ACT_END);
        if ((x_ext_c >= H_SY_BEG) && (x_ext_c < H_SY_END)) begin
            raw_c.hsync = SYNC_POL;
        end
        if ((y_ext_c >= V_SY_BEG) && (y_ext_c < V_SY_END)) begin
            raw_c.vsync = SYNC_POL;
        end
        raw_c.sof = (x_q == '0) && (y_q == '0);
    end

    vga_delay_line #(
        .WIDTH   ($bits(vga_ctl_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (CTL_IDLE)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .ce  (vif.pix_ce),
        .d   (raw_c),
        .q   (dly_c)
    );

    assign vif.x         = x_q;
    assign vif.y         = y_q;
    assign vif.frame_cnt = frame_q;
    assign vif.hsync     = dly_c.hsync;
    assign vif.vsync     = dly_c.vsync;
    assign vif.video_on  = dly_c.video_on;
    // Strobes only exist on the clock that carries the pixel tick
    assign vif.sof       = dly_c.sof & vif.pix_ce;
    assign vif.eol       = line_end_c & vif.pix_ce & ~rst;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen over three configurations (VGA, tiny, SVGA).
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit pol; int dly; int fw;
    } cfg_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        sof;
        logic        eol;
        logic [7:0]  fc;
    } obs_t;

    localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 0, 8};
    localparam cfg_t CFG_B = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 3, 2};
    localparam cfg_t CFG_C = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 2, 8};

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    always #5 clk = ~clk;

    vga_timing_if #(.CNT_W(11), .FRAME_W(8)) if_a ();
    vga_timing_if #(.CNT_W(4),  .FRAME_W(2)) if_b ();
    vga_timing_if #(.CNT_W(11), .FRAME_W(8)) if_c ();

    vga_timing_gen #(.PIPE_DLY(0)) u_a (.clk(clk), .rst(rst_a), .vif(if_a));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIPE_DLY(3), .CNT_W(4), .FRAME_W(2)
    ) u_b (.clk(clk), .rst(rst_b), .vif(if_b));

    vga_timing_gen #(
        .H_ACTIVE(SVGA_800x600_60.h.active), .H_FP(SVGA_800x600_60.h.fp),
        .H_SYNC(SVGA_800x600_60.h.sync),     .H_BP(SVGA_800x600_60.h.bp),
        .V_ACTIVE(SVGA_800x600_60.v.active), .V_FP(SVGA_800x600_60.v.fp),
        .V_SYNC(SVGA_800x600_60.v.sync),     .V_BP(SVGA_800x600_60.v.bp),
        .SYNC_POL(bit'(SVGA_800x600_60.pol)), .PIPE_DLY(2)
    ) u_c (.clk(clk), .rst(rst_c), .vif(if_c));

    obs_t obs_a, obs_b, obs_c;
    always_comb obs_a = '{if_a.x, if_a.y, if_a.hsync, if_a.vsync, if_a.video_on,
                          if_a.sof, if_a.eol, if_a.frame_cnt};
    always_comb obs_b = '{11'(if_b.x), 11'(if_b.y), if_b.hsync, if_b.vsync, if_b.video_on,
                          if_b.sof, if_b.eol, 8'(if_b.frame_cnt)};
    always_comb obs_c = '{if_c.x, if_c.y, if_c.hsync, if_c.vsync, if_c.video_on,
                          if_c.sof, if_c.eol, if_c.frame_cnt};

    int       errors = 0;
    int       checks = 0;
    cfg_t     cur;
    int       cur_sel;
    int       mx, my, mf;
    vga_ctl_t q[$];

    task automatic set_in(input int sel, input logic r, input logic ce);
        case (sel)
            0:       begin rst_a = r; if_a.pix_ce = ce; end
            1:       begin rst_b = r; if_b.pix_ce = ce; end
            default: begin rst_c = r; if_c.pix_ce = ce; end
        endcase
    endtask

    function automatic obs_t get_obs(input int sel);
        case (sel)
            0:       return obs_a;
            1:       return obs_b;
            default: return obs_c;
        endcase
    endfunction

    function automatic vga_ctl_t idle_ctl();
        vga_ctl_t r;
        r.hsync = ~cur.pol; r.vsync = ~cur.pol; r.video_on = 1'b0; r.sof = 1'b0;
        return r;
    endfunction

    function automatic vga_ctl_t raw_model(input int px, input int py);
        vga_ctl_t r;
        bit in_hs, in_vs;
        in_hs = (px >= cur.ha + cur.hf) && (px < cur.ha + cur.hf + cur.hs);
        in_vs = (py >= cur.va + cur.vf) && (py < cur.va + cur.vf + cur.vs);
        r.hsync    = in_hs ? cur.pol : ~cur.pol;
        r.vsync    = in_vs ? cur.pol : ~cur.pol;
        r.video_on = (px < cur.ha) && (py < cur.va);
        r.sof      = (px == 0) && (py == 0);
        return r;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mf = 0;
        q.delete();
        repeat (cur.dly) q.push_back(idle_ctl());
    endtask

    // One clock: drive pix_ce, compare all outputs against the model, then advance it
    task automatic sb_tick(input logic ce, output obs_t o);
        vga_ctl_t e;
        logic sof_e, eol_e;
        int ht, vt;
        ht = cur.ha + cur.hf + cur.hs + cur.hb;
        vt = cur.va + cur.vf + cur.vs + cur.vb;
        @(negedge clk);
        set_in(cur_sel, 1'b0, ce);
        #1;
        o = get_obs(cur_sel);
        if (cur.dly == 0) e = raw_model(mx, my);
        else              e = q[0];
        sof_e = e.sof & ce;
        eol_e = (mx == ht - 1) && ce;
        checks++; if (o.x !== 11'(mx)) begin errors++; $display("FAIL sb_x: got %0d expected %0d at %0t", o.x, mx, $time); end
        checks++; if (o.y !== 11'(my)) begin errors++; $display("FAIL sb_y: got %0d expected %0d at %0t", o.y, my, $time); end
        checks++; if (o.fc !== 8'(mf)) begin errors++; $display("FAIL sb_frame: got %0d expected %0d at %0t", o.fc, mf, $time); end
        checks++; if (o.hs !== e.hsync) begin errors++; $display("FAIL sb_hsync: got %b expected %b x=%0d y=%0d", o.hs, e.hsync, mx, my); end
        checks++; if (o.vs !== e.vsync) begin errors++; $display("FAIL sb_vsync: got %b expected %b x=%0d y=%0d", o.vs, e.vsync, mx, my); end
        checks++; if (o.vo !== e.video_on) begin errors++; $display("FAIL sb_video_on: got %b expected %b x=%0d y=%0d", o.vo, e.video_on, mx, my); end
        checks++; if (o.sof !== sof_e) begin errors++; $display("FAIL sb_sof: got %b expected %b x=%0d y=%0d", o.sof, sof_e, mx, my); end
        checks++; if (o.eol !== eol_e) begin errors++; $display("FAIL sb_eol: got %b expected %b x=%0d y=%0d", o.eol, eol_e, mx, my); end
        if (ce) begin
            if (cur.dly > 0) begin
                q.push_back(raw_model(mx, my));
                void'(q.pop_front());
            end
            if (mx == ht - 1) begin
                mx = 0;
                if (my == vt - 1) begin
                    my = 0;
                    mf = (mf + 1) % (1 << cur.fw);
                end else begin
                    my = my + 1;
                end
            end else begin
                mx = mx + 1;
            end
        end
    endtask

    // Hold reset for one edge and check the inactive state; the next sb_tick releases it
    task automatic do_reset(input int sel, input cfg_t c);
        obs_t o;
        cur_sel = sel;
        cur     = c;
        @(negedge clk);
        set_in(sel, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        o = get_obs(sel);
        checks++; if (o.x !== 11'd0) begin errors++; $display("FAIL reset_x[%0d]: got %0d expected 0", sel, o.x); end
        checks++; if (o.y !== 11'd0) begin errors++; $display("FAIL reset_y[%0d]: got %0d expected 0", sel, o.y); end
        checks++; if (o.fc !== 8'd0) begin errors++; $display("FAIL reset_frame[%0d]: got %0d expected 0", sel, o.fc); end
        checks++; if (o.hs !== ~c.pol) begin errors++; $display("FAIL reset_hsync[%0d]: got %b expected %b", sel, o.hs, ~c.pol); end
        checks++; if (o.vs !== ~c.pol) begin errors++; $display("FAIL reset_vsync[%0d]: got %b expected %b", sel, o.vs, ~c.pol); end
        checks++; if (o.vo !== 1'b0) begin errors++; $display("FAIL reset_video_on[%0d]: got %b expected 0", sel, o.vo); end
        checks++; if (o.sof !== 1'b0 || o.eol !== 1'b0) begin errors++; $display("FAIL reset_strobes[%0d]: got sof=%b eol=%b expected 0 0", sel, o.sof, o.eol); end
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(0, CFG_A);
        do_reset(1, CFG_B);
        do_reset(2, CFG_C);
    endtask

    task automatic test_default_raster();
        obs_t o, prev;
        int hs_fall = -1, hs_rise = -1, vo_fall = -1;
        do_reset(0, CFG_A);
        prev = '0;
        for (int i = 0; i < 2 * 800 + 5; i++) begin
            sb_tick(1'b1, o);
            if (i > 0) begin
                if (prev.hs && !o.hs && hs_fall < 0) hs_fall = int'(o.x);
                if (!prev.hs && o.hs && hs_rise < 0) hs_rise = int'(o.x);
                if (prev.vo && !o.vo && vo_fall < 0) vo_fall = int'(o.x);
            end
            prev = o;
        end
        checks++; if (hs_fall != 656) begin errors++; $display("FAIL vga_hsync_fall: got x=%0d expected 656", hs_fall); end
        checks++; if (hs_rise != 752) begin errors++; $display("FAIL vga_hsync_rise: got x=%0d expected 752", hs_rise); end
        checks++; if (vo_fall != 640) begin errors++; $display("FAIL vga_video_end: got x=%0d expected 640", vo_fall); end
        checks++; if (prev.y !== 11'd2 || prev.x !== 11'd4) begin errors++; $display("FAIL vga_position: got x=%0d y=%0d expected x=4 y=2", prev.x, prev.y); end
    endtask

    task automatic test_ce_div4();
        obs_t o;
        int sof_at[$];
        int eol_at[$];
        do_reset(1, CFG_B);
        for (int i = 0; i < 2 * 480 + 10; i++) begin
            sb_tick(logic'(i % 4 == 3), o);
            if (o.sof) sof_at.push_back(i);
            if (o.eol) eol_at.push_back(i);
        end
        checks++;
        if (sof_at.size() < 2) begin errors++; $display("FAIL div4_sof_count: got %0d pulses expected >=2", sof_at.size()); end
        else if (sof_at[1] - sof_at[0] != 480) begin errors++; $display("FAIL div4_frame_period: got %0d clks expected 480", sof_at[1] - sof_at[0]); end
        checks++;
        if (eol_at.size() < 2) begin errors++; $display("FAIL div4_eol_count: got %0d pulses expected >=2", eol_at.size()); end
        else if (eol_at[1] - eol_at[0] != 60) begin errors++; $display("FAIL div4_line_period: got %0d clks expected 60", eol_at[1] - eol_at[0]); end
    endtask

    task automatic test_pipe_delay();
        obs_t o;
        int xb;
        int t_x = -1, t_h = -1, t_s = -1;
        do_reset(1, CFG_B);
        for (int i = 0; i < 40; i++) begin
            xb = mx;
            sb_tick(1'b1, o);
            if (xb == 10 && t_x < 0) t_x = i;
            if (!o.hs && t_h < 0) t_h = i;
            if (o.sof && t_s < 0) t_s = i;
        end
        checks++; if (t_x < 0 || t_h - t_x != 3) begin errors++; $display("FAIL dly_hsync_lag: got %0d ticks expected 3", t_h - t_x); end
        checks++; if (t_s != 3) begin errors++; $display("FAIL dly_sof_lag: got %0d ticks expected 3", t_s); end
    endtask

    task automatic test_frame_wrap();
        obs_t o;
        int seen[$];
        int exp_seq[5];
        logic [7:0] pf;
        exp_seq = '{1, 2, 3, 0, 1};
        do_reset(1, CFG_B);
        pf = 8'd0;
        for (int i = 0; i < 5 * 120 + 5; i++) begin
            sb_tick(1'b1, o);
            if (o.fc !== pf) begin
                seen.push_back(int'(o.fc));
                checks++;
                if (o.x !== 11'd0 || o.y !== 11'd0) begin errors++; $display("FAIL wrap_align: got x=%0d y=%0d expected 0 0", o.x, o.y); end
                pf = o.fc;
            end
        end
        checks++; if (seen.size() != 5) begin errors++; $display("FAIL wrap_count: got %0d expected 5", seen.size()); end
        for (int k = 0; k < 5 && k < seen.size(); k++) begin
            checks++;
            if (seen[k] != exp_seq[k]) begin errors++; $display("FAIL wrap_seq[%0d]: got %0d expected %0d", k, seen[k], exp_seq[k]); end
        end
    endtask

    task automatic test_mid_reset();
        obs_t o;
        int t_s = -1;
        do_reset(1, CFG_B);
        repeat (50) sb_tick(1'b1, o);
        @(negedge clk);
        set_in(1, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        o = get_obs(1);
        checks++; if (o.x !== 11'd0 || o.y !== 11'd0) begin errors++; $display("FAIL midrst_pos: got x=%0d y=%0d expected 0 0", o.x, o.y); end
        checks++; if (o.hs !== 1'b1 || o.vs !== 1'b1) begin errors++; $display("FAIL midrst_sync: got hs=%b vs=%b expected 1 1", o.hs, o.vs); end
        checks++; if (o.vo !== 1'b0 || o.sof !== 1'b0) begin errors++; $display("FAIL midrst_flush: got vo=%b sof=%b expected 0 0", o.vo, o.sof); end
        model_reset();
        for (int i = 0; i < 20; i++) begin
            sb_tick(1'b1, o);
            if (o.sof && t_s < 0) t_s = i;
        end
        checks++; if (t_s != 3) begin errors++; $display("FAIL midrst_sof_lag: got %0d ticks expected 3", t_s); end
    endtask

    task automatic test_svga_line();
        obs_t o;
        int hi_cnt = 0, first_hi = -1;
        do_reset(2, CFG_C);
        for (int i = 0; i < 1060; i++) begin
            sb_tick(1'b1, o);
            if (o.hs) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = int'(o.x);
            end
        end
        checks++; if (hi_cnt != 128) begin errors++; $display("FAIL svga_hsync_width: got %0d expected 128", hi_cnt); end
        checks++; if (first_hi != 842) begin errors++; $display("FAIL svga_hsync_start: got x=%0d expected 842", first_hi); end
        checks++; if (o.y !== 11'd1) begin errors++; $display("FAIL svga_line_wrap: got y=%0d expected 1", o.y); end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        if_a.pix_ce = 1'b0; if_b.pix_ce = 1'b0; if_c.pix_ce = 1'b0;
        cur = CFG_A; cur_sel = 0;
        test_reset();
        test_default_raster();
        test_ce_div4();
        test_pipe_delay();
        test_frame_wrap();
        test_mid_reset();
        test_svga_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
